// File: rtl/cmd_frame_master_pkg.sv
// Shared opcodes, command-type and state encodings for the host-side command framer.
package cmd_frame_master_pkg;

    localparam logic [7:0] RF_WR_CMD    = 8'hAA;
    localparam logic [7:0] RF_RD_CMD    = 8'hBB;
    localparam logic [7:0] ALU_W_OP_CMD = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD  = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'b00,
        CMD_RF_RD   = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEND    = 3'd1;
    localparam logic [2:0] ST_WAIT_LO = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Index of the final byte of each frame (frame length minus one).
    function automatic logic [1:0] frame_last_idx(input cmd_type_e t);
        logic [1:0] r;
        case (t)
            CMD_RF_WR:  r = 2'd2;
            CMD_RF_RD:  r = 2'd1;
            CMD_ALU_OP: r = 2'd3;
            default:    r = 2'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_frame_master_rsp_timer.sv
// Per-byte response watchdog: counts waiting cycles, expires at TIMEOUT_CYC-1.
module rsp_timer #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_CLR,
    input  logic i_EN,
    output logic o_EXPIRE
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_CLR)
            cnt_d = '0;
        else if (i_EN && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_EXPIRE = i_EN && (cnt_q == LAST);

endmodule

// File: rtl/cmd_frame_master.sv
// Serializes one register-file/ALU command to UART TX, then gathers the
// response bytes from UART RX into a result word with a per-byte timeout.
module cmd_frame_master #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int TIMEOUT_CYC   = 65535
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_CMD_VLD,
    input  logic [1:0]                i_CMD_TYPE,
    input  logic [ADDR_WIDTH-1:0]     i_ADDR,
    input  logic [DATA_WIDTH-1:0]     i_WR_DATA,
    input  logic [DATA_WIDTH-1:0]     i_OPA,
    input  logic [DATA_WIDTH-1:0]     i_OPB,
    input  logic [ALU_FUN_WIDTH-1:0]  i_FUN,
    output logic                      o_CMD_BUSY,
    output logic [DATA_WIDTH-1:0]     o_TX_DATA,
    output logic                      o_TX_VLD,
    input  logic                      i_TX_BUSY,
    input  logic [DATA_WIDTH-1:0]     i_RX_DATA,
    input  logic                      i_RX_VLD,
    output logic [2*DATA_WIDTH-1:0]   o_RSP_DATA,
    output logic                      o_DONE,
    output logic                      o_TIMEOUT
);
    import cmd_frame_master_pkg::*;

    logic [2:0]               state_q, state_d;
    cmd_type_e                ctype_q, ctype_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]    opa_q, opa_d;
    logic [DATA_WIDTH-1:0]    opb_q, opb_d;
    logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
    logic [1:0]               idx_q, idx_d;
    logic                     tx_vld_q, tx_vld_d;
    logic [DATA_WIDTH-1:0]    tx_dat_q, tx_dat_d;
    logic [DATA_WIDTH-1:0]    lsb_q, lsb_d;
    logic [2*DATA_WIDTH-1:0]  rsp_q, rsp_d;

    logic tmr_en, tmr_clr, tmr_expire;

    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input cmd_type_e                t,
        input logic [1:0]               idx,
        input logic [ADDR_WIDTH-1:0]    a,
        input logic [DATA_WIDTH-1:0]    wd,
        input logic [DATA_WIDTH-1:0]    oa,
        input logic [DATA_WIDTH-1:0]    ob,
        input logic [ALU_FUN_WIDTH-1:0] f
    );
        logic [DATA_WIDTH-1:0] b;
        b = '0;
        case (t)
            CMD_RF_WR:
                case (idx)
                    2'd0:    b = DATA_WIDTH'(RF_WR_CMD);
                    2'd1:    b = DATA_WIDTH'(a);
                    default: b = wd;
                endcase
            CMD_RF_RD:
                b = (idx == 2'd0) ? DATA_WIDTH'(RF_RD_CMD) : DATA_WIDTH'(a);
            CMD_ALU_OP:
                case (idx)
                    2'd0:    b = DATA_WIDTH'(ALU_W_OP_CMD);
                    2'd1:    b = oa;
                    2'd2:    b = ob;
                    default: b = DATA_WIDTH'(f);
                endcase
            default:
                b = (idx == 2'd0) ? DATA_WIDTH'(ALU_NOP_CMD) : DATA_WIDTH'(f);
        endcase
        return b;
    endfunction

    // Timer runs only while waiting; any received byte restarts the window.
    assign tmr_en  = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
    assign tmr_clr = !tmr_en || i_RX_VLD;

    rsp_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rsp_timer (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_CLR    (tmr_clr),
        .i_EN     (tmr_en),
        .o_EXPIRE (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        ctype_d  = ctype_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        fun_d    = fun_q;
        idx_d    = idx_q;
        tx_vld_d = tx_vld_q;
        tx_dat_d = tx_dat_q;
        lsb_d    = lsb_q;
        rsp_d    = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (i_CMD_VLD) begin
                    ctype_d  = cmd_type_e'(i_CMD_TYPE);
                    addr_d   = i_ADDR;
                    wdat_d   = i_WR_DATA;
                    opa_d    = i_OPA;
                    opb_d    = i_OPB;
                    fun_d    = i_FUN;
                    idx_d    = 2'd0;
                    tx_vld_d = 1'b1;
                    tx_dat_d = frame_byte(cmd_type_e'(i_CMD_TYPE), 2'd0, i_ADDR,
                                          i_WR_DATA, i_OPA, i_OPB, i_FUN);
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_TX_BUSY) begin
                    if (idx_q == frame_last_idx(ctype_q)) begin
                        tx_vld_d = 1'b0;
                        tx_dat_d = '0;
                        if (ctype_q == CMD_RF_WR) begin
                            rsp_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT_LO;
                        end
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        tx_dat_d = frame_byte(ctype_q, idx_d, addr_q, wdat_q,
                                              opa_q, opb_q, fun_q);
                    end
                end
            end
            ST_WAIT_LO: begin
                if (i_RX_VLD) begin
                    lsb_d = i_RX_DATA;
                    if (ctype_q == CMD_RF_RD) begin
                        rsp_d   = {{DATA_WIDTH{1'b0}}, i_RX_DATA};
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_HI;
                    end
                end else if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (i_RX_VLD) begin
                    rsp_d   = {i_RX_DATA, lsb_q};
                    state_d = ST_DONE;
                end else if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q  <= ST_IDLE;
            ctype_q  <= CMD_RF_WR;
            addr_q   <= '0;
            wdat_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            fun_q    <= '0;
            idx_q    <= '0;
            tx_vld_q <= 1'b0;
            tx_dat_q <= '0;
            lsb_q    <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            ctype_q  <= ctype_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            fun_q    <= fun_d;
            idx_q    <= idx_d;
            tx_vld_q <= tx_vld_d;
            tx_dat_q <= tx_dat_d;
            lsb_q    <= lsb_d;
            rsp_q    <= rsp_d;
        end
    end

    assign o_CMD_BUSY = (state_q != ST_IDLE);
    assign o_TX_VLD   = tx_vld_q;
    assign o_TX_DATA  = tx_dat_q;
    assign o_RSP_DATA = rsp_q;
    assign o_DONE     = (state_q == ST_DONE);
    // Pulses in the last waiting cycle so the block is idle on the next one.
    assign o_TIMEOUT  = tmr_expire && !i_RX_VLD;

endmodule

// File: tb/tb_cmd_frame_master.sv
// Randomized bench for cmd_frame_master against a frame/response model.
module tb_cmd_frame_master;
    localparam int TO = 16;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_CMD_VLD;
    logic [1:0]  i_CMD_TYPE;
    logic [3:0]  i_ADDR;
    logic [7:0]  i_WR_DATA, i_OPA, i_OPB;
    logic [3:0]  i_FUN;
    logic        o_CMD_BUSY;
    logic [7:0]  o_TX_DATA;
    logic        o_TX_VLD;
    logic        i_TX_BUSY;
    logic [7:0]  i_RX_DATA;
    logic        i_RX_VLD;
    logic [15:0] o_RSP_DATA;
    logic        o_DONE;
    logic        o_TIMEOUT;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] last_rsp;

    always #5 i_CLK = ~i_CLK;

    cmd_frame_master #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYC(TO)
    ) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_CMD_VLD(i_CMD_VLD), .i_CMD_TYPE(i_CMD_TYPE),
        .i_ADDR(i_ADDR), .i_WR_DATA(i_WR_DATA), .i_OPA(i_OPA), .i_OPB(i_OPB),
        .i_FUN(i_FUN), .o_CMD_BUSY(o_CMD_BUSY), .o_TX_DATA(o_TX_DATA),
        .o_TX_VLD(o_TX_VLD), .i_TX_BUSY(i_TX_BUSY), .i_RX_DATA(i_RX_DATA),
        .i_RX_VLD(i_RX_VLD), .o_RSP_DATA(o_RSP_DATA), .o_DONE(o_DONE),
        .o_TIMEOUT(o_TIMEOUT)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check_eq({tag, "_busy"},    o_CMD_BUSY, 0);
        check_eq({tag, "_tx_vld"},  o_TX_VLD,   0);
        check_eq({tag, "_tx_dat"},  o_TX_DATA,  0);
        check_eq({tag, "_rsp"},     o_RSP_DATA, 0);
        check_eq({tag, "_done"},    o_DONE,     0);
        check_eq({tag, "_timeout"}, o_TIMEOUT,  0);
    endtask

    // Issue one command and play the UART peer; entered and left at posedge+1.
    task automatic do_cmd(input logic [1:0] ct, input logic [3:0] ad, input logic [7:0] wd,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn,
                          input logic [7:0] r0, input logic [7:0] r1, input int nrx,
                          input int busy_pct, input int stall_at, input int stall_len,
                          input bit stray);
        logic [7:0]  fr[$];
        logic [7:0]  rxb[2];
        logic [15:0] exp_rsp;
        logic [7:0]  prev_dat;
        int need, sent, rx_sent, gap, wait_start, stall_left, busy_seen;
        bit ws_set, fin, hold_prev;

        fr = {};
        case (ct)
            2'b00: begin fr.push_back(8'hAA); fr.push_back({4'h0, ad}); fr.push_back(wd); need = 0; end
            2'b01: begin fr.push_back(8'hBB); fr.push_back({4'h0, ad}); need = 1; end
            2'b10: begin fr.push_back(8'hCC); fr.push_back(a); fr.push_back(b);
                         fr.push_back({4'h0, fn}); need = 2; end
            default: begin fr.push_back(8'hDD); fr.push_back({4'h0, fn}); need = 2; end
        endcase
        rxb[0] = r0;
        rxb[1] = r1;
        exp_rsp = (ct == 2'b00) ? 16'h0000 : (ct == 2'b01) ? {8'h00, r0} : {r1, r0};

        sent = 0; rx_sent = 0; gap = $urandom_range(0, 3); wait_start = 0;
        stall_left = stall_len; busy_seen = 0; ws_set = 0; fin = 0;
        hold_prev = 0; prev_dat = 8'h00;

        i_CMD_VLD = 1'b1; i_CMD_TYPE = ct; i_ADDR = ad; i_WR_DATA = wd;
        i_OPA = a; i_OPB = b; i_FUN = fn; i_TX_BUSY = 1'b0; i_RX_VLD = 1'b0;
        @(negedge i_CLK);
        check_eq("idle_at_accept", o_CMD_BUSY, 0);
        @(posedge i_CLK); #1;
        i_CMD_VLD = 1'b0;
        i_ADDR = 4'($urandom); i_WR_DATA = 8'($urandom); i_OPA = 8'($urandom);
        i_OPB = 8'($urandom); i_FUN = 4'($urandom); i_CMD_TYPE = 2'($urandom);

        for (int cyc = 1; cyc < 400; cyc++) begin
            if (!ws_set && sent == fr.size()) begin
                ws_set = 1;
                wait_start = cyc;
                check_eq("no_bubble", wait_start, fr.size() + 1 + busy_seen);
            end
            if (sent == stall_at && stall_left > 0) begin
                i_TX_BUSY = 1'b1;
                stall_left--;
            end else begin
                i_TX_BUSY = ($urandom_range(0, 99) < busy_pct);
            end
            if (ws_set && rx_sent < nrx) begin
                if (gap == 0) begin
                    i_RX_VLD = 1'b1; i_RX_DATA = rxb[rx_sent]; rx_sent++;
                    wait_start = cyc + 1; gap = $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
            if (stray && cyc == 1) begin
                i_CMD_VLD = 1'b1; i_CMD_TYPE = ~ct; i_RX_VLD = 1'b1; i_RX_DATA = 8'hEE;
            end
            @(negedge i_CLK);
            if (cyc == 1) begin
                check_eq("tx_vld_rise", o_TX_VLD, 1);
                check_eq("busy_in_send", o_CMD_BUSY, 1);
            end
            if (hold_prev) check_eq("tx_hold", o_TX_DATA, prev_dat);
            if (o_TX_VLD) begin
                check_eq("tx_in_frame", sent < fr.size(), 1);
                if (i_TX_BUSY) busy_seen++;
                else if (sent < fr.size()) begin
                    check_eq("tx_byte", o_TX_DATA, fr[sent]);
                    sent++;
                end
            end
            hold_prev = o_TX_VLD && i_TX_BUSY;
            prev_dat  = o_TX_DATA;
            if (o_DONE || o_TIMEOUT) begin
                check_eq("done_to_excl", o_DONE && o_TIMEOUT, 0);
                check_eq("end_is_timeout", o_TIMEOUT, nrx < need);
                check_eq("end_cycle", cyc, (nrx < need) ? wait_start + TO - 1 : wait_start);
                if (nrx >= need) last_rsp = exp_rsp;
                check_eq("rsp_data", o_RSP_DATA, last_rsp);
                fin = 1;
                break;
            end
            @(posedge i_CLK); #1;
            i_CMD_VLD = 1'b0; i_RX_VLD = 1'b0;
        end
        check_eq("end_seen", fin, 1);
        @(posedge i_CLK); #1;
        i_CMD_VLD = 1'b0; i_RX_VLD = 1'b0; i_TX_BUSY = 1'b0;
        check_eq("idle_after_end", o_CMD_BUSY, 0);
        check_eq("tx_vld_after_end", o_TX_VLD, 0);
        check_eq("pulse_after_end", o_DONE | o_TIMEOUT, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_RST = 1'b0; i_CMD_VLD = 1'b0; i_CMD_TYPE = 2'b00; i_ADDR = '0;
        i_WR_DATA = '0; i_OPA = '0; i_OPB = '0; i_FUN = '0;
        i_TX_BUSY = 1'b0; i_RX_DATA = '0; i_RX_VLD = 1'b0; last_rsp = 16'h0;
        repeat (3) @(posedge i_CLK);
        @(negedge i_CLK);
        check_rst("reset");
        @(posedge i_CLK); #1;
        i_RST = 1'b1;
        @(posedge i_CLK); #1;

        do_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 0, 0, -1, 0, 0);
        do_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 8'h7E, 8'h00, 1, 0, -1, 0, 0);
        do_cmd(2'b10, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h2, 8'h2C, 8'h01, 2, 0, 2, 3, 0);
        do_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h55, 8'h66, 1, 0, -1, 0, 0);
        do_cmd(2'b10, 4'h3, 8'h00, 8'h91, 8'h27, 4'h9, 8'h44, 8'h88, 2, 0, -1, 0, 1);

        // Abort a read while it waits for its response byte.
        i_CMD_VLD = 1'b1; i_CMD_TYPE = 2'b01; i_ADDR = 4'h9; i_TX_BUSY = 1'b0;
        @(posedge i_CLK); #1;
        i_CMD_VLD = 1'b0;
        repeat (3) @(posedge i_CLK);
        #1;
        i_RST = 1'b0;
        #1;
        check_rst("mid_rst");
        last_rsp = 16'h0;
        @(posedge i_CLK); #1;
        i_RST = 1'b1;
        @(posedge i_CLK); #1;
        do_cmd(2'b01, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0, 8'hA5, 8'h00, 1, 0, -1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] ct;
            int need, nrx;
            ct   = 2'($urandom);
            need = (ct == 2'b00) ? 0 : (ct == 2'b01) ? 1 : 2;
            nrx  = (need > 0 && $urandom_range(0, 4) == 0) ? need - 1 : need;
            do_cmd(ct, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                   8'($urandom), 8'($urandom), nrx, ($urandom_range(0, 1) == 1) ? 40 : 0,
                   -1, 0, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
